// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Single-digit 0..9 down-counter for the DE-board display path. The start
// value is loaded from SW while idle. KEY[1] starts, pauses and resumes the
// count. The digit decrements once every TICK_DIV clocks and is shown on HEX0.
// Reaching zero latches the DONE state.
//
// Ports
//   CLOCK_50  in   1  system clock; every flop is rising-edge on this clock
//   KEY       in   2  KEY[0]: async active-low reset
//                     KEY[1]: start/pause button, active-low, asynchronous
//   SW        in   4  start value, unsigned; values 10..15 load as 9
//   HEX0      out  7  active-low segments, bit 0 = a ... bit 6 = g
//   LEDG      out  2  LEDG[0] = DONE state, LEDG[1] = RUN state
//
// Parameter
//   TICK_DIV  clocks per decrement; must be >= 4 and even
//
// Optional feature macro: COUNTDOWN_DONE_BLINK_EN
//   When defined, HEX0 blinks "0" / blank every TICK_DIV/2 clocks in DONE,
//   starting with "0" on entry. When undefined, DONE shows a steady "0".
// -----------------------------------------------------------------------------
module countdown_timer #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic       CLOCK_50,
   input  logic [1:0] KEY,
   input  logic [3:0] SW,
   output logic [6:0] HEX0,
   output logic [1:0] LEDG
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);
`ifdef COUNTDOWN_DONE_BLINK_EN
   localparam logic [CW-1:0] TICK_HALF = CW'(TICK_DIV / 2);
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [3:0]    digit;
   logic [3:0]    digit_next;
   logic [3:0]    digit_dec;
   logic [3:0]    sw_clamped;
   logic [CW-1:0] tick_cnt;
   logic [CW-1:0] tick_cnt_next;
   logic          cnt_wrap;
   logic          cnt_active;
   logic          tick;
   logic          rst_n;
   logic          key_sync1;
   logic          key_sync2;
   logic          key_prev;
   logic          press;
   logic [6:0]    seg_digit;

   assign rst_n = KEY[0];

   // ---------------------------------------------------------------------------
   // Button conditioning: two-flop synchronizer plus a previous-value flop.
   // The button is active-low, so a press is a 1 -> 0 transition of sync2.
   // Reset to 1 so that releasing reset never looks like a press.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         key_sync1 <= 1'b1;
         key_sync2 <= 1'b1;
         key_prev  <= 1'b1;
      end else begin
         key_sync1 <= KEY[1];
         key_sync2 <= key_sync1;
         key_prev  <= key_sync2;
      end
   end

   assign press = key_prev & ~key_sync2;

   assign sw_clamped = (SW > 4'd9) ? 4'd9 : SW;
   // Saturating decrement keeps the digit from ever wrapping below 0.
   assign digit_dec  = (digit == 4'd0) ? 4'd0 : (digit - 4'd1);

   // ---------------------------------------------------------------------------
   // Tick counter. It advances only while the FSM stays in a counting state,
   // so entering RUN (from IDLE or PAUSE) always starts a full period and any
   // partial period at a pause is discarded.
   // ---------------------------------------------------------------------------
   assign cnt_wrap = (tick_cnt == TICK_MAX);
   assign tick     = (state == S_RUN) && cnt_wrap;

`ifdef COUNTDOWN_DONE_BLINK_EN
   assign cnt_active = ((state == S_RUN)  && (state_next == S_RUN)) ||
                       ((state == S_DONE) && (state_next == S_DONE));
`else
   assign cnt_active = (state == S_RUN) && (state_next == S_RUN);
`endif

   always_comb begin
      tick_cnt_next = '0;
      if (cnt_active) begin
         tick_cnt_next = cnt_wrap ? '0 : (tick_cnt + CW'(1));
      end
   end

   // ---------------------------------------------------------------------------
   // State machine: registered state, combinational next state.
   // In RUN a simultaneous press and tick applies the decrement first; reaching
   // zero wins over the pause request.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         digit    <= 4'd0;
         tick_cnt <= '0;
      end else begin
         state    <= state_next;
         digit    <= digit_next;
         tick_cnt <= tick_cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      digit_next = digit;
      case (state)
         S_IDLE: begin
            digit_next = sw_clamped;
            if (press) begin
               state_next = (sw_clamped != 4'd0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            if (tick) begin
               digit_next = digit_dec;
               if (digit_dec == 4'd0) begin
                  state_next = S_DONE;
               end else if (press) begin
                  state_next = S_PAUSE;
               end
            end else if (press) begin
               state_next = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (press) begin
               state_next = S_RUN;
            end
         end
         S_DONE: begin
            digit_next = 4'd0;
            if (press) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
            digit_next = 4'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      seg_digit = 7'h7F;
      case (digit)
         4'd0:    seg_digit = 7'b1000000;
         4'd1:    seg_digit = 7'b1111001;
         4'd2:    seg_digit = 7'b0100100;
         4'd3:    seg_digit = 7'b0110000;
         4'd4:    seg_digit = 7'b0011001;
         4'd5:    seg_digit = 7'b0010010;
         4'd6:    seg_digit = 7'b0000010;
         4'd7:    seg_digit = 7'b1111000;
         4'd8:    seg_digit = 7'b0000000;
         4'd9:    seg_digit = 7'b0010000;
         default: seg_digit = 7'h7F;
      endcase
   end

`ifdef COUNTDOWN_DONE_BLINK_EN
   // The counter starts at 0 on DONE entry, so the first half period shows "0".
   assign HEX0 = ((state == S_DONE) && (tick_cnt >= TICK_HALF)) ? 7'h7F : seg_digit;
`else
   assign HEX0 = seg_digit;
`endif

   assign LEDG = {(state == S_RUN), (state == S_DONE)};

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Drives countdown_timer with TICK_DIV = 10. After every rising edge the
// stimulus advances a reference model and queues the expected {LEDG, HEX0};
// a monitor on the falling edge pops and compares against the DUT.
//
// The reference model works in terms of edge numbers: a press is recognised
// from the button level seen two and three edges back, and in RUN the digit
// drops whenever the number of edges since RUN entry is a multiple of TICK_DIV.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

   localparam int TD = 10;
   localparam int W  = 9;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic [1:0] key;
   logic [3:0] sw;
   logic [6:0] hex0;
   logic [1:0] ledg;

   always #5 clk = ~clk;

   countdown_timer #(.TICK_DIV(TD)) dut (
      .CLOCK_50 (clk),
      .KEY      (key),
      .SW       (sw),
      .HEX0     (hex0),
      .LEDG     (ledg)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   // ---------------- reference model ----------------
   int m_mode, m_digit, m_run_entry, m_done_entry;
   bit k0, k1, k2, k3;   // button level at edges n, n-1, n-2, n-3

   function automatic void model_reset();
      m_mode  = M_IDLE;
      m_digit = 0;
      k0 = 1'b1; k1 = 1'b1; k2 = 1'b1; k3 = 1'b1;
   endfunction

   function automatic void model_edge();
      bit pr;
      int cl;
      int el;
      k3 = k2; k2 = k1; k1 = k0; k0 = key[1];
      pr = k3 & ~k2;
      cl = (int'(sw) > 9) ? 9 : int'(sw);
      case (m_mode)
         M_IDLE: begin
            m_digit = cl;
            if (pr) begin
               if (cl != 0) begin
                  m_mode = M_RUN;  m_run_entry = cyc;
               end else begin
                  m_mode = M_DONE; m_done_entry = cyc;
               end
            end
         end
         M_RUN: begin
            el = cyc - m_run_entry;
            if (el % TD == 0) begin
               m_digit = m_digit - 1;
               if (m_digit == 0) begin
                  m_mode = M_DONE; m_done_entry = cyc;
               end else if (pr) begin
                  m_mode = M_PAUSE;
               end
            end else if (pr) begin
               m_mode = M_PAUSE;
            end
         end
         M_PAUSE: if (pr) begin
            m_mode = M_RUN; m_run_entry = cyc;
         end
         default: if (pr) m_mode = M_IDLE;
      endcase
   endfunction

   function automatic logic [W-1:0] model_out();
      logic [6:0] h;
      h = seg_tbl[m_digit];
`ifdef COUNTDOWN_DONE_BLINK_EN
      if (m_mode == M_DONE && ((cyc - m_done_entry) % TD) >= TD / 2) h = 7'h7F;
`endif
      return {(m_mode == M_RUN), (m_mode == M_DONE), h};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (key[0] == 1'b0) model_reset();
      else                model_edge();
      exp_q.push_back(model_out());
   endtask

   // Button low for three edges then released; acted on three edges after call.
   task automatic do_press();
      key[1] = 1'b0;
      repeat (3) step();
      key[1] = 1'b1;
      step();
   endtask

   // Time a press so the FSM acts on it at edge 'target'.
   task automatic press_to_land(input int target);
      while (cyc < target - 3) step();
      do_press();
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] g;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         g = {ledg, hex0};
         n_checks++;
         if (g !== e) begin
            n_errors++;
            $display("FAIL out_chk edge=%0d got ledg=%b hex=%b want ledg=%b hex=%b",
                     cyc, g[8:7], g[6:0], e[8:7], e[6:0]);
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, edge=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int e;
      model_reset();
      key = 2'b10;
      sw  = 4'd0;
      repeat (3) step();            // reset state checked while held
      key[0] = 1'b1;
      step();

      // Full count from 3, then linger in DONE
      sw = 4'd3;
      step();
      do_press();
      repeat (60) step();
      do_press();                   // DONE -> IDLE
      repeat (2) step();

      // Clamp and zero start
      sw = 4'd13;
      repeat (3) step();
      sw = 4'd0;
      step();
      do_press();                   // straight to DONE
      repeat (8) step();
      do_press();
      sw = 4'd7;                    // IDLE follows SW with one clock latency
      repeat (3) step();

      // Pause / resume
      sw = 4'd5;
      step();
      do_press();
      e = m_run_entry;
      press_to_land(e + 25);        // pause with digit 3
      repeat (15) step();
      do_press();                   // resume, fresh full period
      repeat (50) step();
      do_press();
      repeat (2) step();

      // Press coincident with the last tick: DONE wins
      sw = 4'd1;
      step();
      do_press();
      e = m_run_entry;
      press_to_land(e + TD);
      repeat (4) step();
      do_press();
      repeat (2) step();

      // Press coincident with a tick at digit 4: PAUSE with digit 3
      sw = 4'd4;
      step();
      do_press();
      e = m_run_entry;
      press_to_land(e + TD);
      repeat (6) step();
      do_press();
      repeat (35) step();
      do_press();
      repeat (2) step();

      // Asynchronous reset mid-RUN with digit 6
      sw = 4'd6;
      step();
      do_press();
      repeat (5) step();
      key[0] = 1'b0;                // no clock edge before the next sample
      void'(exp_q.pop_back());
      model_reset();
      exp_q.push_back(model_out());
      sw = 4'd4;
      repeat (2) step();
      key[0] = 1'b1;
      repeat (3) step();

      // Randomised button and switch activity
      for (int b = 0; b < 40; b++) begin
         int hi_len;
         hi_len = $urandom_range(1, 30);
         for (int i = 0; i < hi_len; i++) begin
            if ($urandom_range(0, 7) == 0) sw = 4'($urandom_range(0, 15));
            step();
         end
         key[1] = 1'b0;
         repeat ($urandom_range(1, 4)) step();
         key[1] = 1'b1;
      end
      repeat (3) step();

      // Drain and final queue check
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL queue_drain got %0d entries left want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Single-digit 0–9 down-counter for the DE-board display path, the counting-down counterpart of the existing up-counting 0–9 display timer. The start value is taken from SW. A push-button starts, pauses and resumes the count. The digit decrements once per TICK_DIV clocks, shows on HEX0, and latches a DONE indication at zero. The block is top-level board logic and drives HEX0/LEDG directly from the 50 MHz system clock; there is no derived clock.

## Interface
- TICK_DIV, 50_000_000: clocks per decrement (1 s at 50 MHz); must be ≥ 4 and even; benches override to 10.
- CLOCK_50  input  1  system clock; every flop is rising-edge on this clock.
- KEY  input  2  KEY[0]: asynchronous active-low reset. KEY[1]: start/pause button, active-low, asynchronous to the clock.
- SW  input  4  start value, unsigned binary.
- HEX0  output  7  segment drive for digit, active-low, bit 0 = segment a … bit 6 = segment g.
- LEDG  output  2  LEDG[0]: DONE state. LEDG[1]: RUN state.

## Operation
- Reset (KEY[0] low, asynchronous assert, synchronous-to-clock release is not required):
  - State is IDLE, digit = 0, tick counter = 0, sync flops = 1.
  - Outputs: HEX0 = 7'b1000000 ("0"), LEDG = 2'b00.
- Button conditioning:
  - KEY[1] passes through a 2-flop synchronizer followed by a previous-value flop.
  - press = prev & ~sync2, a one-cycle pulse per falling edge.
  - Holding the button produces exactly one press.
  - There is no debounce; benches drive clean edges.
- Digit register: 4 bits, always within 0..9.
  - SW values 10–15 load as 9.
- Tick counter:
  - Width is $clog2(TICK_DIV).
  - Counts only in RUN and is held at 0 in every other state.
  - When it reaches TICK_DIV-1 it produces tick and wraps to 0.
- State machine, evaluated on each rising edge:
  - IDLE: digit ← clamp(SW) every cycle. On press: to RUN if clamp(SW) ≠ 0, otherwise to DONE with digit = 0.
  - RUN: on tick, digit ← digit-1. If digit was 1, go to DONE. On press without tick, go to PAUSE.
  - RUN, press and tick in the same cycle: decrement applies first. If the result is 0 the next state is DONE, otherwise PAUSE.
  - PAUSE: digit is held. On press, go to RUN; the tick counter restarts from 0, so the partial period is discarded.
  - DONE: digit is held at 0. On press, go to IDLE.
  - The digit never wraps below 0.
- Outputs:
  - HEX0 is a combinational 7-segment decode of the digit (standard active-low 0–9 patterns).
  - LEDG[0] = (state == DONE), LEDG[1] = (state == RUN).

## Timing
- Press latency: KEY[1] low set up before edge k is acted on at edge k+2. The state change is visible after edge k+2.
- First decrement happens exactly TICK_DIV clocks after the edge that enters RUN. Subsequent decrements are spaced TICK_DIV clocks apart.
- Start value N ≥ 1 reaches DONE N·TICK_DIV clocks after entering RUN, provided there are no pauses.
- In IDLE, HEX0 follows an SW change with 1 clock of latency.
- KEY[0] asserted mid-count sends the block to IDLE immediately, with no clock required. On release, the block resumes IDLE loading from SW on the next edge.

## Configuration
- Macro: COUNTDOWN_DONE_BLINK_EN.
- When defined:
  - The tick counter also runs in DONE.
  - HEX0 alternates between "0" and blank (7'h7F) every TICK_DIV/2 clocks, starting with "0" shown on DONE entry.
  - On leaving DONE, the blink phase resets and the tick counter is cleared.
- When undefined: HEX0 shows a steady "0" in DONE and the tick counter stays at 0 outside RUN.
- LEDG behaviour is identical with and without the macro.

## Test plan
All scenarios use TICK_DIV = 10.
- Reset: pulse KEY[0] low mid-RUN with digit 6 -> state is IDLE immediately, HEX0 = 7'b1000000, LEDG = 0; one clock after release, with SW = 4, HEX0 = 7'b0011001.
- Full count: SW = 3, one press -> LEDG[1] is set at edge k+2; HEX0 shows 3, 2, 1, 0 at 10-clock spacing; LEDG = 2'b01 exactly 30 clocks after RUN entry.
- Clamp and zero: SW = 13 loads HEX0 = "9" (7'b0010000); SW = 0 with a press goes straight to DONE with LEDG = 2'b01.
- Pause/resume: SW = 5, press, wait 25 clocks, press again -> digit is held at 3 in PAUSE; press again -> next decrement arrives 10 clocks after RUN re-entry.
- Simultaneous events: press timed to reach the FSM in the same cycle as the tick at digit 1 -> goes to DONE, not PAUSE. At digit 4 the same timing gives PAUSE with digit 3.
- Blink (macro defined): in DONE, HEX0 toggles between 7'b1000000 and 7'h7F every 5 clocks; a press returns to IDLE with HEX0 = clamp(SW) decode.
